// File: rtl/mem_port_arbiter_pkg.sv
// Shared cache definitions: line/address defaults and the memory-port arbiter state encoding.
package mem_port_arbiter_pkg;

  // Block address (byte address bits 31:4) and cache-line widths.
  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Side identifiers, also used for the last-grant record.
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  // Winner of an IDLE arbitration; only meaningful when at least one side requests.
  function automatic logic pick_side(input logic req_i_side,
                                     input logic req_d_side,
                                     input logic last_side,
                                     input logic rr_en);
    logic side;
    if (req_i_side && req_d_side) begin
      side = rr_en ? ~last_side : SIDE_D;
    end else if (req_d_side) begin
      side = SIDE_D;
    end else begin
      side = SIDE_I;
    end
    return side;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single slow memory port between the I-side and D-side L2 caches,
// one transaction at a time, with a one-cycle request-low gap between grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              proc_reset,
  // I-side L2
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // D-side L2
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // Shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_side;
  logic       w_last_side_nxt;
  logic       w_i_req;
  logic       w_d_req;
  logic       w_win_side;
  logic       w_rr_en;

  assign w_i_req    = i_read | i_write;
  assign w_d_req    = d_read | d_write;
  assign w_rr_en    = (RR_EN != 0);
  assign w_win_side = pick_side(w_i_req, w_d_req, r_last_side, w_rr_en);

  // State and last-grant registers; reset records D as last so I wins the first tie.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state     <= ST_IDLE;
      r_last_side <= SIDE_D;
    end else begin
      r_state     <= w_state_nxt;
      r_last_side <= w_last_side_nxt;
    end
  end

  // Next state: arbitrate in IDLE, leave a grant on completion or requester abort.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_side_nxt = r_last_side;
    case (r_state)
      ST_IDLE: begin
        if (w_i_req || w_d_req) begin
          w_last_side_nxt = w_win_side;
          w_state_nxt     = (w_win_side == SIDE_D) ? ST_GRANT_D : ST_GRANT_I;
        end
      end
      ST_GRANT_I: begin
        if (mem_ready || !w_i_req) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_GRANT_D: begin
        if (mem_ready || !w_d_req) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Port steering: the granted side talks straight to memory, everything else is quiet.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    case (r_state)
      ST_GRANT_I: begin
        mem_read  = i_read;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
        i_rdata   = mem_rdata;
      end
      ST_GRANT_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        d_rdata   = mem_rdata;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester queues, a fixed-latency memory
// model and a scoreboard of expected completions in grant order.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  typedef struct packed {
    logic          side;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
  } txn_t;

  logic          clk;
  logic          proc_reset;
  logic          sel;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          mem_ready_m;
  logic [DW-1:0] mem_rdata_m;
  logic          a_mem_ready, b_mem_ready;

  logic [DW-1:0] a_i_rdata, a_d_rdata, a_mem_wdata, b_i_rdata, b_d_rdata, b_mem_wdata;
  logic          a_i_ready, a_d_ready, a_mem_read, a_mem_write;
  logic          b_i_ready, b_d_ready, b_mem_read, b_mem_write;
  logic [AW-1:0] a_mem_addr, b_mem_addr;

  logic [DW-1:0] o_i_rdata, o_d_rdata, o_mem_wdata;
  logic          o_i_ready, o_d_ready, o_mem_read, o_mem_write;
  logic [AW-1:0] o_mem_addr;

  txn_t i_q[$];
  txn_t d_q[$];
  txn_t sb[$];
  logic i_act, d_act, gap_pending;
  int   mem_cnt, mem_lat;
  int   n_tests, n_fail;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) u_dut_rr (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata_m), .mem_ready(a_mem_ready)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) u_dut_fp (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata_m), .mem_ready(b_mem_ready)
  );

  // Only the selected instance sees the memory model.
  assign a_mem_ready = mem_ready_m & ~sel;
  assign b_mem_ready = mem_ready_m & sel;
  assign o_i_rdata   = sel ? b_i_rdata   : a_i_rdata;
  assign o_d_rdata   = sel ? b_d_rdata   : a_d_rdata;
  assign o_i_ready   = sel ? b_i_ready   : a_i_ready;
  assign o_d_ready   = sel ? b_d_ready   : a_d_ready;
  assign o_mem_read  = sel ? b_mem_read  : a_mem_read;
  assign o_mem_write = sel ? b_mem_write : a_mem_write;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {4{32'hC0DE_0000 ^ {4'h0, a}}};
  endfunction

  function automatic logic [DW-1:0] wdata_of(input logic [AW-1:0] a);
    return {4{32'h5EED_0000 ^ {4'h0, a}}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_side(input logic side, input logic rd, input logic wr, input logic [AW-1:0] a);
    if (side) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wdata_of(a);
    end else begin
      i_read = rd; i_write = wr; i_addr = a; i_wdata = wdata_of(a);
    end
  endtask

  task automatic req(input logic side, input logic rd, input logic wr, input logic [AW-1:0] a);
    txn_t t;
    t.side = side; t.rd = rd; t.wr = wr; t.addr = a;
    if (side) d_q.push_back(t);
    else i_q.push_back(t);
  endtask

  task automatic exp_txn(input logic side, input logic rd, input logic wr, input logic [AW-1:0] a);
    txn_t t;
    t.side = side; t.rd = rd; t.wr = wr; t.addr = a;
    sb.push_back(t);
  endtask

  task automatic check_completion(input logic side);
    txn_t e;
    chk("ready_expected", 128'(sb.size() != 0), 128'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant_side", 128'(side), 128'(e.side));
    chk("mem_addr", 128'(o_mem_addr), 128'(e.addr));
    chk("mem_read", 128'(o_mem_read), 128'(e.rd));
    chk("mem_write", 128'(o_mem_write), 128'(e.wr));
    if (e.wr) chk("mem_wdata", o_mem_wdata, wdata_of(e.addr));
    chk("rdata", side ? o_d_rdata : o_i_rdata, line_of(e.addr));
  endtask

  // One clock: gap check, memory model, completion check, requester update.
  task automatic tick();
    logic i_done, d_done;
    @(negedge clk);
    if (gap_pending) begin
      chk("release_gap", 128'({o_mem_read, o_mem_write}), 128'd0);
      gap_pending = 1'b0;
    end
    if (mem_ready_m) begin
      mem_ready_m = 1'b0;
      mem_cnt     = 0;
    end else if (o_mem_read || o_mem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_ready_m = 1'b1;
        mem_rdata_m = line_of(o_mem_addr);
      end
    end else begin
      mem_cnt = 0;
    end
    #1;
    i_done = 1'b0;
    d_done = 1'b0;
    if (o_i_ready || o_d_ready) begin
      chk("ready_exclusive", 128'(o_i_ready & o_d_ready), 128'd0);
      if (o_i_ready) begin check_completion(1'b0); i_done = 1'b1; end
      else begin check_completion(1'b1); d_done = 1'b1; end
      gap_pending = 1'b1;
    end
    if (i_done && i_act) begin
      i_q.delete(0); i_act = 1'b0;
      if (i_q.size() == 0) drive_side(1'b0, 1'b0, 1'b0, 28'd0);
    end
    if (d_done && d_act) begin
      d_q.delete(0); d_act = 1'b0;
      if (d_q.size() == 0) drive_side(1'b1, 1'b0, 1'b0, 28'd0);
    end
    if (!i_act && i_q.size() != 0) begin
      drive_side(1'b0, i_q[0].rd, i_q[0].wr, i_q[0].addr); i_act = 1'b1;
    end
    if (!d_act && d_q.size() != 0) begin
      drive_side(1'b1, d_q[0].rd, d_q[0].wr, d_q[0].addr); d_act = 1'b1;
    end
  endtask

  task automatic run_until(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 128'(sb.size()), 128'd0);
    tick();
    tick();
  endtask

  task automatic do_reset(input logic use_fp);
    proc_reset = 1'b1;
    sel = use_fp;
    i_q.delete(); d_q.delete(); sb.delete();
    i_act = 1'b0; d_act = 1'b0; gap_pending = 1'b0;
    drive_side(1'b0, 1'b0, 1'b0, 28'd0);
    drive_side(1'b1, 1'b0, 1'b0, 28'd0);
    mem_ready_m = 1'b0; mem_cnt = 0;
    #1;
    chk("rst_mem_req", 128'({o_mem_read, o_mem_write}), 128'd0);
    chk("rst_ready", 128'({o_i_ready, o_d_ready}), 128'd0);
    chk("rst_mem_addr", 128'(o_mem_addr), 128'd0);
    chk("rst_mem_wdata", o_mem_wdata, 128'd0);
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mem_lat = 4; mem_rdata_m = '0; sel = 1'b0;

    // Single I read, memory answers after 10 grant cycles.
    do_reset(1'b0);
    mem_lat = 10;
    req(1'b0, 1'b1, 1'b0, 28'h0000010);
    exp_txn(1'b0, 1'b1, 1'b0, 28'h0000010);
    tick();
    chk("t1_idle_no_forward", 128'(o_mem_read), 128'd0);
    tick();
    chk("t1_mem_read_next_edge", 128'(o_mem_read), 128'd1);
    chk("t1_mem_addr", 128'(o_mem_addr), 128'h10);
    run_until("t1", 40);

    // Tie right after reset: I first, then D write.
    do_reset(1'b0);
    mem_lat = 3;
    req(1'b0, 1'b1, 1'b0, 28'h10);
    req(1'b1, 1'b0, 1'b1, 28'h20);
    exp_txn(1'b0, 1'b1, 1'b0, 28'h10);
    exp_txn(1'b1, 1'b0, 1'b1, 28'h20);
    run_until("t2", 40);

    // Continuous contention, round-robin alternates.
    do_reset(1'b0);
    mem_lat = 2;
    for (int k = 0; k < 3; k++) begin
      req(1'b0, 1'b1, 1'b0, 28'(32'h100 + 2 * k));
      req(1'b1, 1'b1, 1'b0, 28'(32'h101 + 2 * k));
    end
    for (int k = 0; k < 3; k++) begin
      exp_txn(1'b0, 1'b1, 1'b0, 28'(32'h100 + 2 * k));
      exp_txn(1'b1, 1'b1, 1'b0, 28'(32'h101 + 2 * k));
    end
    run_until("t3", 100);

    // D write-back then refill with I pending: D, I, D.
    mem_lat = 4;
    req(1'b1, 1'b0, 1'b1, 28'h30);
    req(1'b1, 1'b1, 1'b0, 28'h40);
    exp_txn(1'b1, 1'b0, 1'b1, 28'h30);
    exp_txn(1'b0, 1'b1, 1'b0, 28'h44);
    exp_txn(1'b1, 1'b1, 1'b0, 28'h40);
    tick();
    req(1'b0, 1'b1, 1'b0, 28'h44);
    run_until("t4", 80);

    // Simultaneous read and write from one side are forwarded together.
    mem_lat = 2;
    req(1'b1, 1'b1, 1'b1, 28'h70);
    exp_txn(1'b1, 1'b1, 1'b1, 28'h70);
    run_until("t5", 30);

    // Stray mem_ready while idle.
    mem_ready_m = 1'b1;
    mem_rdata_m = line_of(28'h99);
    #1;
    chk("stray_i_ready", 128'(o_i_ready), 128'd0);
    chk("stray_d_ready", 128'(o_d_ready), 128'd0);
    tick();
    chk("stray_stay_idle", 128'({o_mem_read, o_mem_write}), 128'd0);

    // I aborts in its third grant cycle.
    mem_lat = 20;
    i_read = 1'b1; i_addr = 28'h50;
    tick();
    chk("abort_grant_c1", 128'(o_mem_read), 128'd1);
    tick();
    tick();
    chk("abort_grant_c3", 128'(o_mem_read), 128'd1);
    i_read = 1'b0;
    #1;
    chk("abort_drop_same_cycle", 128'(o_mem_read), 128'd0);
    tick();
    chk("abort_release", 128'(o_mem_read), 128'd0);
    i_read = 1'b1; i_addr = 28'h52;
    tick();
    chk("abort_back_idle", 128'(o_mem_read), 128'd0);
    tick();
    chk("abort_regrant", 128'(o_mem_read), 128'd1);
    chk("abort_regrant_addr", 128'(o_mem_addr), 128'h52);
    i_read = 1'b0; i_addr = 28'd0;
    tick();
    tick();
    tick();

    // Reset in the middle of a D write; D re-granted after release.
    mem_lat = 30;
    req(1'b1, 1'b0, 1'b1, 28'h60);
    exp_txn(1'b1, 1'b0, 1'b1, 28'h60);
    tick();
    tick();
    chk("rmid_granted", 128'(o_mem_write), 128'd1);
    tick();
    tick();
    proc_reset = 1'b1;
    #1;
    chk("rmid_write_drops", 128'(o_mem_write), 128'd0);
    chk("rmid_no_d_ready", 128'(o_d_ready), 128'd0);
    tick();
    chk("rmid_held", 128'(o_mem_write), 128'd0);
    proc_reset = 1'b0;
    tick();
    chk("rmid_regrant", 128'(o_mem_write), 128'd1);
    chk("rmid_regrant_addr", 128'(o_mem_addr), 128'h60);
    run_until("t8", 60);

    // Fixed D priority: D keeps winning while it requests.
    do_reset(1'b1);
    mem_lat = 2;
    req(1'b0, 1'b1, 1'b0, 28'h200);
    req(1'b0, 1'b1, 1'b0, 28'h202);
    req(1'b1, 1'b1, 1'b0, 28'h201);
    req(1'b1, 1'b1, 1'b0, 28'h203);
    req(1'b1, 1'b1, 1'b0, 28'h205);
    exp_txn(1'b1, 1'b1, 1'b0, 28'h201);
    exp_txn(1'b1, 1'b1, 1'b0, 28'h203);
    exp_txn(1'b1, 1'b1, 1'b0, 28'h205);
    exp_txn(1'b0, 1'b1, 1'b0, 28'h200);
    exp_txn(1'b0, 1'b1, 1'b0, 28'h202);
    run_until("t9", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
